seq_detect_prog: RTL
====================

Name: seq_detect_prog

Overview:
- Programmable Moore-style serial pattern detector; the parametrised successor to the team's fixed 1101 non-overlapping detector.
- Pattern length, pattern value and overlap mode are set at runtime, within compile-time bounds.
- Input is a qualified serial bit stream.
- Sits between a serial receiver front-end and control logic that consumes a one-cycle match pulse.

Parameters:
- PAT_W, 8: maximum pattern length in bits (2..32).
- LEN_W, 4: width of cfg_len; must hold PAT_W.
- DEF_PAT, 8'b0000_1101: pattern loaded at reset.
- DEF_LEN, 4: pattern length loaded at reset.
- DEF_OVL, 1'b0: overlap mode at reset (0 = non-overlapping).
- CNT_W, 8: match counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  x is sampled only when high.
- x  in  1  serial data bit.
- cfg_load  in  1  one-cycle strobe; captures cfg_pattern, cfg_len, cfg_overlap.
- cfg_pattern  in  PAT_W  pattern; bit [len-1] is the first bit in time, bit [0] the last.
- cfg_len  in  LEN_W  active length; legal range 2..PAT_W.
- cfg_overlap  in  1  1 = overlapping detection.
- y  out  1  registered match pulse.
- state  out  2  current FSM state (debug).
- match_cnt  out  CNT_W  saturating match count; present only when the optional feature is compiled in.

Behaviour:
- Reset (rst=1 at an edge):
  - pattern/len/overlap registers = DEF_PAT/DEF_LEN/DEF_OVL.
  - History shift register = 0; fill counter = 0.
  - y = 0; state = FILL (2'b00); match_cnt = 0.
  - Reset has priority over cfg_load and in_valid. Reset mid-pattern discards all partial progress.
- History update: on an edge with in_valid=1, hist <= {hist[PAT_W-2:0], x}. With in_valid=0, hist, fill and state hold; y goes to 0.
- Fill counter counts valid bits since the last clear and saturates at len.
- FSM states:
  - FILL (00): fill < len after the update.
  - ARMED (01): fill == len, no match.
  - MATCH (10): Moore state asserting y.
- Transitions:
  - Match condition: a valid bit whose update makes fill reach len AND hist[len-1:0] == pattern[len-1:0] (computed on the updated history). This bit moves the FSM to MATCH.
  - From MATCH, the next edge always leaves. Next state is evaluated as from ARMED (overlap=1) or FILL (overlap=0), using the new bit if in_valid=1.
  - Otherwise the next state is ARMED or FILL according to fill.
- Output and latency:
  - y = 1 exactly while state == MATCH; registered, no combinational path from x.
  - y rises on the edge that samples the final pattern bit and is high for that one cycle. This gives one cycle latency from the last bit presented.
- Overlap modes:
  - overlap=0: on entering MATCH, fill clears to 0. The matched bits cannot contribute to the next match; hist is not cleared.
  - overlap=1: fill stays at len, so back-to-back matches are allowed.
- Consecutive matches: with overlap=1 and a valid bit that matches again, the FSM goes MATCH->MATCH and y stays high for multiple cycles, one cycle per match.
- cfg_load:
  - Captures cfg_pattern, cfg_len and cfg_overlap.
  - Clears hist and fill; state <= FILL; y <= 0.
  - The in_valid bit in the same cycle is discarded.
  - cfg_len outside 2..PAT_W is clamped: values <2 become 2, values >PAT_W become PAT_W.
- Pattern bits above len-1 are ignored in the compare.

Optional Feature:
- Macro: SEQDET_MATCH_CNT_EN.
- Defined:
  - match_cnt port and register exist.
  - Increments by 1 on every edge entering or remaining in MATCH; saturates at 2^CNT_W-1.
  - Cleared by rst and by cfg_load.
- Undefined: port and register are absent; all other behaviour is identical.

Decomposition:
- Package seq_detect_pkg holds:
  - state encoding constants: ST_FILL=2'b00, ST_ARMED=2'b01, ST_MATCH=2'b10.
  - default parameter values.
  - the length-clamp function.
- Sub-module seq_detect_hist: shift register, fill counter with clear/saturate, and masked comparator producing a single hit signal.
- The top level holds the FSM, config registers and counter.

Test Plan:
- Defaults, non-overlap; after rst, in_valid=1, stream 1,1,0,1,1,0,1 -> y=1 for exactly one cycle, on the edge sampling bit 4. No second pulse. match_cnt=1.
- Same stream after cfg_load with overlap=1, pattern=1101, len=4 -> y pulses on the edges sampling bits 4 and 7. match_cnt=2.
- Stream 1,1,0,1 with in_valid=0 for 3 cycles between bits 2 and 3 -> state holds during the gaps; y=1 only on the edge sampling the final 1.
- rst asserted after 1,1,0 then released, followed by 1 -> no match. The next full 1101 matches.
- cfg_load pattern=8'b1010_0111, len=8, overlap=1; stream the pattern twice -> two single-cycle pulses, 8 valid bits apart.
- cfg_len=0 and cfg_len=15 (LEN_W=4, PAT_W=8) -> effective lengths 2 and 8 respectively. With CNT_W=2, overlap=1, pattern 11, len=2, stream 6 ones -> match_cnt saturates at 3.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// ============================================================================
//  Module      : seq_detect_pkg
//  Description : Shared state encoding, default configuration values and the
//                pattern-length clamp helper for the programmable detector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_detect_pkg;

    // FSM state encoding, also exported on the debug state port
    typedef enum logic [1:0] {
        ST_FILL  = 2'b00,
        ST_ARMED = 2'b01,
        ST_MATCH = 2'b10
    } state_t;

    // Default parameter values
    localparam int          SEQDET_PAT_W   = 8;
    localparam int          SEQDET_LEN_W   = 4;
    localparam logic [7:0]  SEQDET_DEF_PAT = 8'b0000_1101;
    localparam int          SEQDET_DEF_LEN = 4;
    localparam logic        SEQDET_DEF_OVL = 1'b0;
    localparam int          SEQDET_CNT_W   = 8;

    // Force a requested length into the usable range 2..pat_w
    function automatic int clamp_len(input int len, input int pat_w);
        if (len < 2) begin
            return 2;
        end
        if (len > pat_w) begin
            return pat_w;
        end
        return len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_detect_hist.sv
// ============================================================================
//  Module      : seq_detect_hist
//  Description : Serial history shift register, saturating fill counter and
//                length-masked pattern comparator. The hit output is judged
//                on the history as it will be after the current edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_hist
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = SEQDET_PAT_W,
    parameter int LEN_W = SEQDET_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             x,
    input  logic             overlap,
    input  logic [LEN_W-1:0] len,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit,
    output logic             fill_full
);

    logic [PAT_W-1:0] hist_q, hist_d, hist_upd;
    logic [LEN_W-1:0] fill_q, fill_d, fill_upd;
    logic             cmp_ok;

    // Post-update history/fill, masked compare and clear handling
    always_comb begin
        hist_upd = hist_q;
        fill_upd = fill_q;
        if (shift) begin
            hist_upd = {hist_q[PAT_W-2:0], x};
            if (fill_q < len) begin
                fill_upd = fill_q + 1'b1;
            end
        end

        // Only the low len bits take part; upper pattern bits are don't-care
        cmp_ok = 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
            if ((i < int'(len)) && (hist_upd[i] != pattern[i])) begin
                cmp_ok = 1'b0;
            end
        end

        hit = shift && (fill_upd == len) && cmp_ok;

        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else begin
            hist_d = hist_upd;
            // Non-overlapping mode: matched bits may not seed the next match
            fill_d = (hit && !overlap) ? '0 : fill_upd;
        end

        fill_full = (fill_d == len);
    end

    // History and fill registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_detect_prog.sv
// ============================================================================
//  Module      : seq_detect_prog
//  Description : Programmable Moore serial pattern detector. Runtime pattern,
//                length and overlap mode; registered one-cycle match pulse.
//                Optional saturating match counter enabled by defining
//                SEQDET_MATCH_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = SEQDET_PAT_W,
    parameter int               LEN_W   = SEQDET_LEN_W,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(SEQDET_DEF_PAT),
    parameter int               DEF_LEN = SEQDET_DEF_LEN,
    parameter logic             DEF_OVL = SEQDET_DEF_OVL,
    parameter int               CNT_W   = SEQDET_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             x,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    output logic             y,
    output logic [1:0]       state
`ifdef SEQDET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    state_t           state_q, state_d;
    logic             y_q, y_d;
    logic             hit;
    logic             fill_full;
    logic             shift;

    // A bit arriving alongside cfg_load is dropped
    assign shift = in_valid && !cfg_load;

    seq_detect_hist #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .clr       (cfg_load),
        .shift     (shift),
        .x         (x),
        .overlap   (ovl_q),
        .len       (len_q),
        .pattern   (pat_q),
        .hit       (hit),
        .fill_full (fill_full)
    );

    // Configuration capture with length clamping
    always_comb begin
        pat_d = pat_q;
        len_d = len_q;
        ovl_d = ovl_q;
        if (cfg_load) begin
            pat_d = cfg_pattern;
            len_d = LEN_W'(clamp_len(int'(cfg_len), PAT_W));
            ovl_d = cfg_overlap;
        end
    end

    // Next state: a hit always lands in MATCH, otherwise fill decides
    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = ST_FILL;
        end else if (hit) begin
            state_d = ST_MATCH;
        end else if (fill_full) begin
            state_d = ST_ARMED;
        end else begin
            state_d = ST_FILL;
        end
        y_d = (state_d == ST_MATCH);
    end

    // Configuration and FSM registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= DEF_PAT;
            len_q   <= LEN_W'(DEF_LEN);
            ovl_q   <= DEF_OVL;
            state_q <= ST_FILL;
            y_q     <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    assign y     = y_q;
    assign state = state_q;

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of edges that enter or stay in MATCH
    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load) begin
            cnt_d = '0;
        end else if ((state_d == ST_MATCH) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Match counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule

`default_nettype wire
